neural_stage_feeder: RTL

//  Hardware source for neural_stage: accepts input vectors over a valid/ready stream, double-buffers them,
//  and replays each vector as N back-to-back words with a 'first' pulse, a tap index, and a bias word

---
 rtl/neural_stage_feeder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/neural_stage_feeder.sv
// Double-buffered vector feeder for neural_stage: collects N-word vectors, replays them
// word by word with first/tap_index, and presents each vector's bias LATENCY cycles after its first.
module neural_stage_feeder #(
  parameter int unsigned N       = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [DW-1:0]        in_bias,
  output logic                 stage_valid,
  output logic                 first,
  output logic [DW-1:0]        stage_data,
  output logic [$clog2(N)-1:0] tap_index,
  output logic [DW-1:0]        stage_bias,
  output logic                 bias_valid
);

  localparam int unsigned TW = $clog2(N);
  localparam logic [TW-1:0] LAST = TW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [DW-1:0] mem [2][N];
  logic [DW-1:0] bank_bias [2];
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank, rd_bank_nxt, other_bank;
  logic [TW-1:0] wr_cnt;
  logic          wr_fire, wr_done, rd_free;
  state_t        state, state_nxt;
  logic          load, rd_sel, first_nxt;
  logic [TW-1:0] rd_addr;
  logic [DW-1:0] data_nxt, cur_bias, cur_bias_nxt;
  logic [DW:0]   dly [LATENCY];
  logic [TW-1:0] hold_cnt;

  assign in_ready   = !full[wr_bank];
  assign wr_fire    = in_valid && in_ready;
  assign wr_done    = wr_fire && (wr_cnt == LAST);
  assign other_bank = ~rd_bank;

  // Bank storage; only ever written while the target bank is not full
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= in_data;
      if (wr_cnt == '0) bank_bias[wr_bank] <= in_bias;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  // Writer and reader never complete on the same bank in one cycle
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_free) full_nxt[rd_bank] = 1'b0;
  end

  // Read FSM: computes the next registered output word
  always_comb begin
    state_nxt    = state;
    rd_bank_nxt  = rd_bank;
    rd_free      = 1'b0;
    load         = 1'b0;
    rd_sel       = rd_bank;
    rd_addr      = '0;
    first_nxt    = 1'b0;
    cur_bias_nxt = cur_bias;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt    = RUN;
          load         = 1'b1;
          first_nxt    = 1'b1;
          cur_bias_nxt = bank_bias[rd_bank];
        end
      end
      RUN: begin
        if (tap_index == LAST) begin
          rd_free     = 1'b1;
          rd_bank_nxt = other_bank;
          // A bank completing this very cycle still chains without a gap
          if (full[other_bank] || (wr_done && (wr_bank == other_bank))) begin
            load         = 1'b1;
            rd_sel       = other_bank;
            first_nxt    = 1'b1;
            cur_bias_nxt = bank_bias[other_bank];
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          load    = 1'b1;
          rd_addr = tap_index + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    data_nxt = load ? mem[rd_sel][rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      full        <= '0;
      stage_valid <= 1'b0;
      first       <= 1'b0;
      stage_data  <= '0;
      tap_index   <= '0;
      cur_bias    <= '0;
    end else begin
      state       <= state_nxt;
      rd_bank     <= rd_bank_nxt;
      full        <= full_nxt;
      stage_valid <= load;
      first       <= first_nxt;
      stage_data  <= data_nxt;
      tap_index   <= rd_addr;
      cur_bias    <= cur_bias_nxt;
    end
  end

  // Bias delay line fed from next-state values so stage_bias lands exactly LATENCY after first
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) dly[i] <= '0;
      stage_bias <= '0;
      bias_valid <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      dly[0] <= {first_nxt, cur_bias_nxt};
      for (int unsigned i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
      if (dly[LATENCY-1][DW]) begin
        stage_bias <= dly[LATENCY-1][DW-1:0];
        bias_valid <= 1'b1;
        hold_cnt   <= '0;
      end else if (bias_valid) begin
        if (hold_cnt == LAST) bias_valid <= 1'b0;
        else                  hold_cnt   <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
